// File: rtl/miner_pkg.sv
// miner_pkg: widths, FSM/status encodings and small helpers shared by the
// nonce scheduler and the hashing core.
package miner_pkg;

  localparam int BLOCK_W     = 608;  // header bits, nonce excluded
  localparam int NONCE_W     = 32;
  localparam int HASH_W      = 256;
  localparam int TIMEOUT_CYC = 2048; // max cycles spent waiting on one hash
  localparam int TIMER_W     = 12;
  localparam int COUNT_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DRAIN,
    FIN
  } state_t;

  typedef enum logic [2:0] {
    ST_NONE      = 3'd0,
    ST_FOUND     = 3'd1,
    ST_EXHAUSTED = 3'd2,
    ST_ABORTED   = 3'd3,
    ST_TIMEOUT   = 3'd4,
    ST_ECHO_ERR  = 3'd5
  } status_t;

  // Saturating increment for the completed-hash counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// hash_target_cmp: unsigned hash < target check. Vectors are declared
// [0:W-1] so bit 0 is the leftmost and therefore the most significant bit,
// which is exactly what the built-in relational operator assumes.
module hash_target_cmp
  import miner_pkg::*;
#(
  parameter int W = HASH_W
) (
  input  logic [0:W-1] hash,
  input  logic [0:W-1] target,
  output logic         lt
);

  // Strictly less: a hash equal to the target is not a solution.
  assign lt = (hash < target);

endmodule

// File: rtl/miner_nonce_scheduler.sv
// miner_nonce_scheduler: walks one hashing core through an inclusive nonce
// range for a single header/target job. One enable pulse per hash, waits for
// the core's finished pulse, compares the hash against the target and stops
// on found, range exhausted, abort, timeout or a nonce echo mismatch.
module miner_nonce_scheduler
  import miner_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [0:BLOCK_W-1] job_block,
  input  logic [0:HASH_W-1]  job_target,
  input  logic [0:NONCE_W-1] nonce_start,
  input  logic [0:NONCE_W-1] nonce_end,
  output logic               core_hash_enable,
  output logic [0:BLOCK_W-1] core_block,
  output logic [0:HASH_W-1]  core_target,
  output logic [0:NONCE_W-1] core_nonce,
  input  logic [0:HASH_W-1]  core_hash,
  input  logic [0:NONCE_W-1] core_nonce_echo,
  input  logic               core_finished,
  output logic               busy,
  output logic               done,
  output logic [2:0]         status,
  output logic [0:NONCE_W-1] result_nonce,
  output logic [0:HASH_W-1]  result_hash,
  output logic [31:0]        hash_count
);

  // Last timer value before a wait is declared hung.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  state_t               state_q, state_d;
  logic [0:BLOCK_W-1]   block_q, block_d;
  logic [0:HASH_W-1]    target_q, target_d;
  logic [0:NONCE_W-1]   cur_q, cur_d;
  logic [0:NONCE_W-1]   end_q, end_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [0:HASH_W-1]    hash_q, hash_d;
  logic [0:NONCE_W-1]   echo_q, echo_d;
  logic [COUNT_W-1:0]   hash_count_q, hash_count_d;
  logic                 hash_enable_q, hash_enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  status_t              status_q, status_d;
  logic [0:NONCE_W-1]   result_nonce_q, result_nonce_d;
  logic [0:HASH_W-1]    result_hash_q, result_hash_d;

  logic                 hash_lt;
  logic                 go_fin;
  status_t              fin_status;
  logic                 timer_expired;

  hash_target_cmp #(
    .W (HASH_W)
  ) u_cmp (
    .hash   (hash_q),
    .target (target_q),
    .lt     (hash_lt)
  );

  assign timer_expired = (timer_q == TIMER_LAST);

  // Next-state, datapath and registered-output decode for the job FSM.
  always_comb begin
    // NOTE: every _d starts from its held value so no branch can leave one
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d        = state_q;
    block_d        = block_q;
    target_d       = target_q;
    cur_d          = cur_q;
    end_d          = end_q;
    timer_d        = timer_q;
    hash_d         = hash_q;
    echo_d         = echo_q;
    hash_count_d   = hash_count_q;
    status_d       = status_q;
    result_nonce_d = result_nonce_q;
    result_hash_d  = result_hash_q;
    done_d         = 1'b0;
    go_fin         = 1'b0;
    fin_status     = ST_NONE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          block_d      = job_block;
          target_d     = job_target;
          cur_d        = nonce_start;
          end_d        = nonce_end;
          hash_count_d = '0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        timer_d = '0;
        if (abort) begin
          go_fin     = 1'b1;
          fin_status = ST_ABORTED;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (abort) begin
          // A finish landing with the abort is simply dropped; otherwise
          // drain so the outstanding finish cannot leak into the next job.
          if (core_finished || timer_expired) begin
            go_fin     = 1'b1;
            fin_status = ST_ABORTED;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
            state_d = DRAIN;
          end
        end else if (core_finished) begin
          hash_d       = core_hash;
          echo_d       = core_nonce_echo;
          hash_count_d = sat_inc(hash_count_q);
          state_d      = CHECK;
        end else if (timer_expired) begin
          go_fin     = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      CHECK: begin
        if (abort) begin
          go_fin     = 1'b1;
          fin_status = ST_ABORTED;
        end else if (echo_q != cur_q) begin
          go_fin     = 1'b1;
          fin_status = ST_ECHO_ERR;
        end else if (hash_lt) begin
          go_fin     = 1'b1;
          fin_status = ST_FOUND;
        end else if (cur_q == end_q) begin
          go_fin     = 1'b1;
          fin_status = ST_EXHAUSTED;
        end else begin
          // Wraps through all-ones to zero, so end < start sweeps the gap.
          cur_d   = cur_q + NONCE_W'(1);
          state_d = ISSUE;
        end
      end

      DRAIN: begin
        if (core_finished || timer_expired) begin
          go_fin     = 1'b1;
          fin_status = ST_ABORTED;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status and results change in the same cycle done is high.
    if (go_fin) begin
      state_d        = FIN;
      done_d         = 1'b1;
      status_d       = fin_status;
      result_nonce_d = cur_q;
      result_hash_d  = (fin_status == ST_FOUND) ? hash_q : '0;
    end

    hash_enable_d = (state_d == ISSUE);
    busy_d        = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the wide job/result registers are reset as well, because they
      // drive outputs that must read zero while the block is in reset.
      state_q        <= IDLE;
      block_q        <= '0;
      target_q       <= '0;
      cur_q          <= '0;
      end_q          <= '0;
      timer_q        <= '0;
      hash_q         <= '0;
      echo_q         <= '0;
      hash_count_q   <= '0;
      hash_enable_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      status_q       <= ST_NONE;
      result_nonce_q <= '0;
      result_hash_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values.
      state_q        <= state_d;
      block_q        <= block_d;
      target_q       <= target_d;
      cur_q          <= cur_d;
      end_q          <= end_d;
      timer_q        <= timer_d;
      hash_q         <= hash_d;
      echo_q         <= echo_d;
      hash_count_q   <= hash_count_d;
      hash_enable_q  <= hash_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      status_q       <= status_d;
      result_nonce_q <= result_nonce_d;
      result_hash_q  <= result_hash_d;
    end
  end

  assign core_hash_enable = hash_enable_q;
  assign core_block       = block_q;
  assign core_target      = target_q;
  assign core_nonce       = cur_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign status           = status_q;
  assign result_nonce     = result_nonce_q;
  assign result_hash      = result_hash_q;
  assign hash_count       = hash_count_q;

endmodule
